// File: rtl/if_fetch_aligner.sv
`timescale 1ns/1ps
// if_fetch_aligner: byte-serial Y86 fetch. Pulls one byte per ack from a
// byte-wide instruction memory, sizes the instruction from its icode, packs
// it onto the 48-bit decode bus and offers it with its PC over valid/ready.
//
// Handshakes:
//   memory : mem_req_o/mem_addr_o are held until mem_ack_i; an ack may
//            arrive in the same cycle as the request (combinational path
//            from mem_ack_i/mem_data_i into the next-state logic only).
//   decode : a transfer happens on a rising edge where valid_o && ready_i;
//            inst_o/pc_o/len_o/invalid_o hold while valid_o && !ready_i.
//   redirect_i beats everything: the in-flight fetch or pending output is
//            dropped and fetching restarts at redirect_pc_i.
module if_fetch_aligner #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 48
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_data_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [2:0]        len_o,
   output logic              invalid_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_OUT    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [2:0]        r_cnt;
   logic [2:0]        r_len;
   logic [5:0][7:0]   r_byte;
   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_pc_out;
   logic [2:0]        r_len_out;
   logic              r_invalid;

   logic [5:0][7:0]   w_byte;
   logic [INST_W-1:0] w_inst;
   logic [3:0]        w_icode;
   logic [2:0]        w_len;
   logic              w_last;
   logic              w_stop;

   // Instruction length in bytes from the icode nibble; C..F count as 1.
   function automatic logic [2:0] f_len(input logic [3:0] ic);
      logic [2:0] l;
      case (ic)
         4'h2, 4'h6, 4'hA, 4'hB: l = 3'd2;
         4'h3, 4'h4, 4'h5:       l = 3'd6;
         4'h7, 4'h8:             l = 3'd5;
         default:                l = 3'd1;
      endcase
      return l;
   endfunction

   // b0 is taken straight from the bus on its ack so the length is known
   // in the same cycle, which lets a 1-byte instruction finish immediately.
   assign w_icode = (r_cnt == 3'd0) ? mem_data_i[7:4] : r_byte[0][7:4];
   assign w_len   = (r_cnt == 3'd0) ? f_len(mem_data_i[7:4]) : r_len;
   assign w_last  = mem_ack_i && ((r_cnt + 3'd1) == w_len);
   assign w_stop  = (r_inst[INST_W-1 -: 4] == 4'h0) || r_invalid;

   // Byte buffer with the byte currently on the bus merged in.
   always_comb begin
      w_byte        = r_byte;
      w_byte[r_cnt] = mem_data_i;
   end

   // Pack the collected bytes onto the decode bus by instruction length.
   always_comb begin
      w_inst = {w_byte[0], w_byte[1], w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      case (w_len)
         3'd1:    w_inst = {w_byte[0], 40'hFF_0000_0000};
         3'd2:    w_inst = {w_byte[0], w_byte[1], 32'h0};
         3'd5:    w_inst = {w_byte[0], 8'hFF, w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
         default: ;
      endcase
   end

   // Fetch FSM: collect bytes, hold the packed result until decode takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_cnt     <= 3'd0;
         r_len     <= 3'd0;
         r_byte    <= '0;
         r_inst    <= 48'h10FF_0000_0000;
         r_pc_out  <= '0;
         r_len_out <= 3'd0;
         r_invalid <= 1'b0;
      end else if (redirect_i) begin
         r_pc    <= redirect_pc_i;
         r_cnt   <= 3'd0;
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               if (mem_ack_i) begin
                  r_byte[r_cnt] <= mem_data_i;
                  if (r_cnt == 3'd0) r_len <= w_len;
                  if (w_last) begin
                     r_cnt     <= 3'd0;
                     r_state   <= S_OUT;
                     r_inst    <= w_inst;
                     r_pc_out  <= r_pc;
                     r_len_out <= w_len;
                     r_invalid <= (w_icode >= 4'hC);
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            S_OUT: begin
               if (ready_i) begin
                  r_pc    <= r_pc + ADDR_W'(r_len_out);
                  r_state <= w_stop ? S_HALTED : S_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_o  = (r_state == S_FETCH);
   assign mem_addr_o = r_pc + ADDR_W'(r_cnt);
   assign valid_o    = (r_state == S_OUT);
   assign inst_o     = r_inst;
   assign pc_o       = r_pc_out;
   assign len_o      = r_len_out;
   assign invalid_o  = r_invalid;

endmodule

// File: doc/if_fetch_aligner.md
# if_fetch_aligner

Byte-serial Y86 instruction fetch unit: reads the instruction stream one byte at a time from a byte-wide instruction memory and determines instruction length from the icode. It assembles each variable-length instruction into the 48-bit instruction bus and presents it with its PC to the decode stage over a valid/ready handshake. It sits between instruction memory and the `id` decode stage and takes PC redirects from execute/writeback.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory byte-address width.
- `INST_W`, 48: instruction bus width. Fixed at 48; other values are unsupported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `mem_req_o`  out  1  byte read request.
- `mem_addr_o`  out  ADDR_W  byte address; stable while `mem_req_o`=1 and no ack.
- `mem_ack_i`  in  1  byte valid on `mem_data_i`; may be high in the same cycle as the request.
- `mem_data_i`  in  8  returned byte.
- `redirect_i`  in  1  load a new PC and abort the current fetch.
- `redirect_pc_i`  in  ADDR_W  new PC.
- `valid_o`  out  1  `inst_o`/`pc_o`/`len_o`/`invalid_o` are valid.
- `ready_i`  in  1  decode accepts this cycle.
- `inst_o`  out  48  assembled instruction.
- `pc_o`  out  ADDR_W  address of byte 0 of `inst_o`.
- `len_o`  out  3  instruction length in bytes.
- `invalid_o`  out  1  icode is illegal.

## Operation
- **Length by icode:**
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPl, A pushl, B popl: 2 bytes.
  - 3 irmovl, 4 rmmovl, 5 mrmovl: 6 bytes.
  - 7 jXX, 8 call: 5 bytes.
  - C–F: length 1, `invalid_o`=1.
- **Bus packing** (bytes b0..b5 in fetch order):
  - `inst_o[47:40]`=b0.
  - Length 1: `[39:0]`=40'hFF00000000.
  - Length 2: `[39:32]`=b1, `[31:0]`=0.
  - Length 6: `[39:32]`=b1, `[31:0]`={b5,b4,b3,b2} (little-endian valC).
  - Length 5: `[39:32]`=8'hFF, `[31:0]`={b4,b3,b2,b1} (little-endian dest).
- **FSM states:** IDLE, FETCH, OUT, HALTED.
  - IDLE → FETCH unconditionally on the next edge.
  - FETCH: `mem_req_o`=1, `mem_addr_o`=pc+cnt.
    - On each `mem_ack_i`, the byte is stored and cnt increments.
    - Length is latched from the b0 ack.
    - When the ack of the final byte arrives, cnt is cleared and the state goes to OUT.
  - OUT: `valid_o`=1, `mem_req_o`=0.
    - On `ready_i`=1: pc ← pc+len (mod 2^ADDR_W).
    - Next state is HALTED if the delivered icode is 0 or invalid, else FETCH.
  - HALTED: `mem_req_o`=0, `valid_o`=0. Left only by redirect.
- **Redirect:** highest priority in every state.
  - On `redirect_i`=1: pc ← `redirect_pc_i`, cnt ← 0, state ← FETCH.
  - Any byte acked in that cycle is discarded.
  - An un-accepted OUT instruction is dropped: `valid_o`=0 the next cycle.
  - A redirect in the same cycle as an OUT handshake wins. The transfer still counts for decode, but the pc update uses `redirect_pc_i`.
- **No prefetch.** The next instruction's first request issues the cycle after the OUT handshake.
- **Wrap-around:** pc+cnt and pc+len wrap modulo 2^ADDR_W. A fetch crossing 0xFFFFFFFF→0 is legal.

## Timing
- **Reset values:**
  - `mem_req_o`=0, `mem_addr_o`=0, `valid_o`=0.
  - `inst_o`=48'h10FF00000000, `pc_o`=0, `len_o`=0, `invalid_o`=0.
  - Internal: pc=0, cnt=0, state=IDLE.
- **After reset release:** IDLE for one cycle; `mem_req_o` rises at the second rising edge with `mem_addr_o`=0.
- **Throughput:** with zero-wait memory (ack in the request cycle), one byte per cycle. An N-byte instruction has `valid_o` high in the cycle after the N-th ack.
- **Handshake:** `inst_o`, `pc_o`, `len_o`, `invalid_o` are registered and hold stable while `valid_o`=1 and `ready_i`=0.
- **Memory side:** `mem_addr_o` is unchanged until acked. The fetcher never drops `mem_req_o` mid-instruction, except on redirect or reset.
- **Reset mid-operation:** asynchronous; all outputs return to their reset values immediately. Partial bytes are lost.
- **Memory latency:** any wait-state count is tolerated; latency adds directly.

## Test plan
- **Zero-wait irmovl:** memory at 0 = 30 F3 78 56 34 12, `ready_i`=1.
  - Required: addresses 0..5 requested on consecutive cycles.
  - `valid_o` asserts with `inst_o`=48'h30F312345678, `pc_o`=0, `len_o`=6.
  - Next request address is 6.
- **jXX at 0x10 with backpressure:** bytes 70 00 01 00 00, `ready_i` low for 3 cycles.
  - Required: `inst_o`=48'h70FF00000100, `len_o`=5, held stable 3 cycles with `mem_req_o`=0.
  - Next address is 0x15 after accept.
- **Redirect mid-fetch:** `redirect_i` with `redirect_pc_i`=0x40 after 3 acked bytes of a 6-byte instruction.
  - Required: no `valid_o` for the partial instruction.
  - Next cycle `mem_addr_o`=0x40, and the instruction delivered has `pc_o`=0x40.
- **Halt:** byte 00 at 0x20.
  - Required: `inst_o`=48'h00FF00000000, `len_o`=1.
  - After accept, `mem_req_o`=0 for 20+ cycles until redirect.
- **Invalid icode:** byte C0.
  - Required: `invalid_o`=1, `len_o`=1, then HALTED.
- **Wrap:** redirect to 0xFFFFFFFF with 6-byte irmovl 30 F3 78 56 34 12 starting there.
  - Required: addresses FFFFFFFF, 0, 1, 2, 3, 4; `pc_o`=32'hFFFFFFFF; next address 5.
- **Wait states:** 2-cycle ack latency.
  - Required: `mem_addr_o` held stable until ack; results identical to the first scenario.
